// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller.
// Walks NUM_MEM memories one after another through the six March C- elements, one
// operation per clock. Read data returns RD_LAT cycles after issue and is checked
// against the expected background word. The block reports pass/fail, the first
// failing memory and address, and a saturating count of miscompared reads.
module mbist_march_ctrl #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = 16'hFFFF,
    parameter int                    NUM_MEM    = 4,
    parameter int                    RD_LAT     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [2:0]            memory_sel,
    output logic                  write_read_mbist,
    output logic [DATA_WIDTH-1:0] wdata_mbist,
    output logic [ADDR_WIDTH-1:0] address_mbist,
    input  logic [DATA_WIDTH-1:0] rdata_mbist,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2:0]            fail_mem,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [7:0]            error_count
);

    localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_reg;
    logic [2:0]            elem_reg;       // March element of the op on the outputs
    logic [ADDR_WIDTH-1:0] addr_reg;       // address of the op on the outputs
    logic                  phase_reg;      // 0 = first op of a two-op element, 1 = second
    logic [DCW-1:0]        drain_cnt_reg;

    // Compare pipeline: one entry per output cycle, tail lines up with rdata_mbist
    logic                  pipe_vld_reg  [RD_LAT];
    logic [DATA_WIDTH-1:0] pipe_exp_reg  [RD_LAT];
    logic [ADDR_WIDTH-1:0] pipe_addr_reg [RD_LAT];
    logic [2:0]            pipe_mem_reg  [RD_LAT];

    logic [2:0]            elem_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  phase_next;
    logic                  last_op;
    logic                  two_op;
    logic                  down;
    logic                  addr_end;
    logic                  miscompare;

    // Op written in elements 0..4: E0 always writes, E1..E4 write on their second op
    function automatic logic op_write(input logic [2:0] e, input logic p);
        op_write = (e == 3'd0) || ((e >= 3'd1) && (e <= 3'd4) && p);
    endfunction

    // Background bit of an op: E1/E3 are (r0,w1), E2/E4 are (r1,w0), E0/E5 use 0
    function automatic logic op_bit(input logic [2:0] e, input logic p);
        case (e)
            3'd1, 3'd3: op_bit = p;
            3'd2, 3'd4: op_bit = ~p;
            default:    op_bit = 1'b0;
        endcase
    endfunction

    // Next op in the March C- sequence after the one currently on the outputs
    always_comb begin
        two_op     = (elem_reg >= 3'd1) && (elem_reg <= 3'd4);
        down       = (elem_reg == 3'd3) || (elem_reg == 3'd4);
        addr_end   = down ? (addr_reg == '0) : (addr_reg == LAST_ADDR);
        elem_next  = elem_reg;
        addr_next  = addr_reg;
        phase_next = 1'b0;
        last_op    = 1'b0;
        if (two_op && !phase_reg) begin
            phase_next = 1'b1;
        end else if (!addr_end) begin
            addr_next = down ? (addr_reg - ADDR_WIDTH'(1)) : (addr_reg + ADDR_WIDTH'(1));
        end else begin
            elem_next = elem_reg + 3'd1;
            // E3 and E4 run downwards, so they begin at the top address
            addr_next = ((elem_reg == 3'd2) || (elem_reg == 3'd3)) ? LAST_ADDR : '0;
            last_op   = (elem_reg == 3'd5);
        end
    end

    // A valid read reaching the pipeline tail is checked against the returned data
    always_comb begin
        miscompare = pipe_vld_reg[RD_LAT-1] && (rdata_mbist != pipe_exp_reg[RD_LAT-1]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                // Capture the op currently presented to the memory
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        pipe_vld_reg[0]  <= 1'b0;
                        pipe_exp_reg[0]  <= '0;
                        pipe_addr_reg[0] <= '0;
                        pipe_mem_reg[0]  <= '0;
                    end else begin
                        pipe_vld_reg[0]  <= (state_reg == S_RUN) && !write_read_mbist;
                        pipe_exp_reg[0]  <= wdata_mbist;
                        pipe_addr_reg[0] <= address_mbist;
                        pipe_mem_reg[0]  <= memory_sel;
                    end
                end
            end else begin : g_stage
                // Delay the entry one more cycle towards the read data
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        pipe_vld_reg[gi]  <= 1'b0;
                        pipe_exp_reg[gi]  <= '0;
                        pipe_addr_reg[gi] <= '0;
                        pipe_mem_reg[gi]  <= '0;
                    end else begin
                        pipe_vld_reg[gi]  <= pipe_vld_reg[gi-1];
                        pipe_exp_reg[gi]  <= pipe_exp_reg[gi-1];
                        pipe_addr_reg[gi] <= pipe_addr_reg[gi-1];
                        pipe_mem_reg[gi]  <= pipe_mem_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Controller FSM with registered memory-side outputs and result tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            elem_reg         <= '0;
            addr_reg         <= '0;
            phase_reg        <= 1'b0;
            drain_cnt_reg    <= '0;
            memory_sel       <= '0;
            write_read_mbist <= 1'b0;
            wdata_mbist      <= '0;
            address_mbist    <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_mem         <= '0;
            fail_addr        <= '0;
            error_count      <= '0;
        end else begin
            if (miscompare) begin
                if (error_count != 8'hFF) begin
                    error_count <= error_count + 8'd1;
                end
                if (error_count == 8'd0) begin
                    fail_mem  <= pipe_mem_reg[RD_LAT-1];
                    fail_addr <= pipe_addr_reg[RD_LAT-1];
                end
            end
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg        <= S_RUN;
                        elem_reg         <= '0;
                        addr_reg         <= '0;
                        phase_reg        <= 1'b0;
                        memory_sel       <= '0;
                        write_read_mbist <= op_write(3'd0, 1'b0);
                        wdata_mbist      <= {DATA_WIDTH{op_bit(3'd0, 1'b0)}};
                        address_mbist    <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        fail_mem         <= '0;
                        fail_addr        <= '0;
                        error_count      <= '0;
                    end
                end
                S_RUN: begin
                    if (last_op) begin
                        state_reg        <= S_DRAIN;
                        drain_cnt_reg    <= '0;
                        write_read_mbist <= 1'b0;
                        wdata_mbist      <= '0;
                        address_mbist    <= '0;
                    end else begin
                        elem_reg         <= elem_next;
                        addr_reg         <= addr_next;
                        phase_reg        <= phase_next;
                        write_read_mbist <= op_write(elem_next, phase_next);
                        wdata_mbist      <= {DATA_WIDTH{op_bit(elem_next, phase_next)}};
                        address_mbist    <= addr_next;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_reg == DCW'(RD_LAT - 1)) begin
                        if (memory_sel == 3'(NUM_MEM - 1)) begin
                            state_reg <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (error_count == 8'd0) && !miscompare;
                        end else begin
                            state_reg        <= S_RUN;
                            memory_sel       <= memory_sel + 3'd1;
                            elem_reg         <= '0;
                            addr_reg         <= '0;
                            phase_reg        <= 1'b0;
                            write_read_mbist <= op_write(3'd0, 1'b0);
                            wdata_mbist      <= {DATA_WIDTH{op_bit(3'd0, 1'b0)}};
                            address_mbist    <= '0;
                        end
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + DCW'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Testbench for mbist_march_ctrl: four small memories behind a mux with a
// three-cycle read return, stuck-at faults injected per bit, and a March C-
// reference model that predicts the op trace and the pass/fail results.
module tb_mbist_march_ctrl;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int NM = 4;
    localparam int NW = 16;
    localparam int RUN_CYC = NM * (10 * NW + 3);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    memory_sel;
    logic          write_read_mbist;
    logic [DW-1:0] wdata_mbist;
    logic [AW-1:0] address_mbist;
    logic [DW-1:0] rdata_mbist;
    logic          busy, done, pass;
    logic [2:0]    fail_mem;
    logic [AW-1:0] fail_addr;
    logic [7:0]    error_count;

    logic [DW-1:0] sa0 [NM][NW];
    logic [DW-1:0] sa1 [NM][NW];
    logic [DW-1:0] mem_arr [NM][NW];
    logic [DW-1:0] rd_q [3];
    logic [71:0]   trace_q [$];
    logic [71:0]   exp_trace [$];
    bit            trace_on = 0;
    int            total = 0;
    int            bad = 0;

    mbist_march_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_ADDR(4'd15), .NUM_MEM(NM), .RD_LAT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .memory_sel(memory_sel),
        .write_read_mbist(write_read_mbist), .wdata_mbist(wdata_mbist),
        .address_mbist(address_mbist), .rdata_mbist(rdata_mbist), .busy(busy),
        .done(done), .pass(pass), .fail_mem(fail_mem), .fail_addr(fail_addr),
        .error_count(error_count)
    );

    always #5 clk = ~clk;

    // Memories + mux: read at issue, data returned three cycles later
    always @(posedge clk) begin
        logic [DW-1:0] v;
        v = (mem_arr[memory_sel[1:0]][address_mbist] & ~sa0[memory_sel[1:0]][address_mbist])
            | sa1[memory_sel[1:0]][address_mbist];
        if (busy && write_read_mbist) mem_arr[memory_sel[1:0]][address_mbist] <= wdata_mbist;
        rd_q[0] <= v;
        rd_q[1] <= rd_q[0];
        rd_q[2] <= rd_q[1];
    end
    assign rdata_mbist = rd_q[2];

    // Record every busy cycle's memory-side outputs
    always @(negedge clk) begin
        if (trace_on && busy)
            trace_q.push_back({memory_sel, write_read_mbist, wdata_mbist, address_mbist});
    end

    task automatic clear_faults();
        for (int m = 0; m < NM; m++)
            for (int a = 0; a < NW; a++) begin
                sa0[m][a] = '0;
                sa1[m][a] = '0;
            end
    endtask

    // Reference: March C- as an element table applied to ideal faulty words
    task automatic model_run(output int e_err, output int e_fm, output int e_fa);
        logic [DW-1:0] m [NW];
        logic [DW-1:0] word, rd;
        int first_val [6] = '{0, 0, 1, 0, 1, 0};
        int nops [6] = '{1, 2, 2, 2, 2, 1};
        bit found = 0;
        bit is_wr;
        int a, val;
        e_err = 0; e_fm = 0; e_fa = 0;
        exp_trace.delete();
        for (int mm = 0; mm < NM; mm++) begin
            for (int k = 0; k < NW; k++) m[k] = '0;
            for (int e = 0; e < 6; e++)
                for (int i = 0; i < NW; i++) begin
                    a = (e == 3 || e == 4) ? (NW - 1 - i) : i;
                    for (int j = 0; j < nops[e]; j++) begin
                        is_wr = (e == 0) || (j == 1);
                        val   = (j == 0) ? first_val[e] : 1 - first_val[e];
                        word  = (val != 0) ? '1 : '0;
                        exp_trace.push_back({3'(mm), is_wr, word, 4'(a)});
                        if (is_wr) m[a] = word;
                        else begin
                            rd = (m[a] & ~sa0[mm][a]) | sa1[mm][a];
                            if (rd !== word) begin
                                if (!found) begin e_fm = mm; e_fa = a; found = 1; end
                                if (e_err < 255) e_err++;
                            end
                        end
                    end
                end
            for (int d = 0; d < 3; d++) exp_trace.push_back({3'(mm), 1'b0, 64'd0, 4'd0});
        end
    endtask

    // Pulse start, optionally pulse it again at busy cycle mid_start, wait for done
    task automatic run_dut(input int mid_start, output int cycles, output bit timeout);
        trace_q.delete();
        trace_on = 1;
        cycles = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            if (busy) cycles++;
            start = (mid_start > 0) && (cycles == mid_start);
            @(negedge clk);
        end
        start = 1'b0;
        timeout = !done;
        trace_on = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({memory_sel, write_read_mbist, wdata_mbist, address_mbist} !== '0) begin
            bad++; $display("FAIL reset_memside: got %h want 0",
                            {memory_sel, write_read_mbist, wdata_mbist, address_mbist});
        end
        total++;
        if ({busy, done, pass, fail_mem, fail_addr, error_count} !== '0) begin
            bad++; $display("FAIL reset_status: got %h want 0",
                            {busy, done, pass, fail_mem, fail_addr, error_count});
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: busy=%0d done=%0d err=%0d", busy, done, error_count);
    endtask

    task automatic test_clean();
        int e_err, e_fm, e_fa, cyc, fb;
        bit to;
        clear_faults();
        model_run(e_err, e_fm, e_fa);
        run_dut(-1, cyc, to);
        $display("clean: cycles=%0d pass=%0d err=%0d", cyc, pass, error_count);
        total++;
        if (to || cyc != RUN_CYC) begin
            bad++; $display("FAIL clean_cycles: got %0d timeout=%0d want %0d", cyc, to, RUN_CYC);
        end
        total++;
        if ({done, busy, pass, error_count} !== {1'b1, 1'b0, 1'b1, 8'd0}) begin
            bad++; $display("FAIL clean_result: done=%0d busy=%0d pass=%0d err=%0d want 1 0 1 0",
                            done, busy, pass, error_count);
        end
        fb = (trace_q.size() == exp_trace.size()) ? -1 : 0;
        for (int i = 0; i < trace_q.size() && fb < 0; i++)
            if (trace_q[i] !== exp_trace[i]) fb = i;
        total++;
        if (fb >= 0) begin
            bad++; $display("FAIL clean_trace: entry %0d got %h want %h (len %0d want %0d)", fb,
                            (fb < trace_q.size()) ? trace_q[fb] : 72'h0, exp_trace[fb],
                            trace_q.size(), exp_trace.size());
        end
        total++;
        if (trace_q.size() < 160 || trace_q[80] !== {3'd0, 1'b0, 64'd0, 4'd15}) begin
            bad++; $display("FAIL first_e3_op: got %h want %h",
                            (trace_q.size() > 80) ? trace_q[80] : 72'h0, {3'd0, 1'b0, 64'd0, 4'd15});
        end
        total++;
        if (trace_q.size() < 160 || trace_q[143] !== {3'd0, 1'b1, 64'd0, 4'd0}) begin
            bad++; $display("FAIL last_e4_op: got %h want %h",
                            (trace_q.size() > 143) ? trace_q[143] : 72'h0, {3'd0, 1'b1, 64'd0, 4'd0});
        end
    endtask

    task automatic test_single_sa0();
        int e_err, e_fm, e_fa, cyc;
        bit to;
        clear_faults();
        sa0[2][7] = 64'h20;
        model_run(e_err, e_fm, e_fa);
        run_dut(-1, cyc, to);
        $display("sa0 m2 a7 b5: pass=%0d fail_mem=%0d fail_addr=%0d err=%0d",
                 pass, fail_mem, fail_addr, error_count);
        total++;
        if (to || {pass, fail_mem, fail_addr, error_count} !== {1'b0, 3'd2, 4'd7, 8'd2}) begin
            bad++; $display("FAIL sa0_result: got pass=%0d mem=%0d addr=%0d err=%0d want 0 2 7 2",
                            pass, fail_mem, fail_addr, error_count);
        end
        total++;
        if (error_count !== 8'(e_err)) begin
            bad++; $display("FAIL sa0_model: err got %0d want %0d", error_count, e_err);
        end
    endtask

    task automatic test_random_faults();
        int e_err, e_fm, e_fa, cyc, nf, m, a;
        bit to;
        logic [DW-1:0] bitm;
        for (int it = 0; it < 4; it++) begin
            clear_faults();
            nf = $urandom_range(1, 4);
            for (int f = 0; f < nf; f++) begin
                m = $urandom_range(0, NM - 1);
                a = $urandom_range(0, NW - 1);
                bitm = 64'd1 << $urandom_range(0, DW - 1);
                if ($urandom_range(0, 1) == 1) sa1[m][a] |= bitm;
                else sa0[m][a] |= bitm;
            end
            model_run(e_err, e_fm, e_fa);
            run_dut(-1, cyc, to);
            $display("random %0d: faults=%0d err=%0d fail_mem=%0d fail_addr=%0d", it, nf,
                     error_count, fail_mem, fail_addr);
            total++;
            if (to || {pass, error_count, fail_mem, fail_addr} !==
                      {1'(e_err == 0), 8'(e_err), 3'(e_fm), 4'(e_fa)}) begin
                bad++; $display("FAIL random_%0d: got pass=%0d err=%0d mem=%0d addr=%0d want %0d %0d %0d %0d",
                                it, pass, error_count, fail_mem, fail_addr, e_err == 0, e_err, e_fm, e_fa);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int cyc;
        bit to;
        clear_faults();
        run_dut(100, cyc, to);
        $display("restart ignored: cycles=%0d pass=%0d", cyc, pass);
        total++;
        if (to || cyc != RUN_CYC || pass !== 1'b1) begin
            bad++; $display("FAIL restart_ignored: cycles got %0d pass=%0d want %0d pass=1",
                            cyc, pass, RUN_CYC);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        bit to;
        clear_faults();
        sa0[0][3] = 64'h1;
        cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 1000 && cyc < 163 + 48 + 4; i++) begin
            if (busy) cyc++;
            @(negedge clk);
        end
        total++;
        if (memory_sel !== 3'd1 || busy !== 1'b1 || error_count !== 8'd2) begin
            bad++; $display("FAIL midrun_position: sel=%0d busy=%0d err=%0d want 1 1 2",
                            memory_sel, busy, error_count);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        $display("reset mid-run: sel=%0d busy=%0d err=%0d", memory_sel, busy, error_count);
        total++;
        if ({memory_sel, write_read_mbist, wdata_mbist, address_mbist, busy, done, pass,
             fail_mem, fail_addr, error_count} !== '0) begin
            bad++; $display("FAIL midrun_reset_outputs: sel=%0d wr=%0d addr=%0d busy=%0d err=%0d want all 0",
                            memory_sel, write_read_mbist, address_mbist, busy, error_count);
        end
        @(negedge clk); rst_n = 1'b1;
        clear_faults();
        run_dut(-1, cyc, to);
        $display("after reset: cycles=%0d pass=%0d err=%0d", cyc, pass, error_count);
        total++;
        if (to || cyc != RUN_CYC || pass !== 1'b1 || error_count !== 8'd0) begin
            bad++; $display("FAIL post_reset_run: cycles=%0d pass=%0d err=%0d want %0d 1 0",
                            cyc, pass, error_count, RUN_CYC);
        end
    endtask

    task automatic test_sa1_addr0();
        int e_err, e_fm, e_fa, cyc;
        bit to;
        clear_faults();
        for (int m = 0; m < NM; m++) sa1[m][0] = 64'd1 << $urandom_range(0, DW - 1);
        model_run(e_err, e_fm, e_fa);
        run_dut(-1, cyc, to);
        $display("sa1 addr0 all mems: err=%0d fail_mem=%0d fail_addr=%0d", error_count, fail_mem, fail_addr);
        total++;
        if (to || {pass, fail_mem, fail_addr, error_count} !== {1'b0, 3'd0, 4'd0, 8'd12}) begin
            bad++; $display("FAIL sa1_addr0: got pass=%0d mem=%0d addr=%0d err=%0d want 0 0 0 12",
                            pass, fail_mem, fail_addr, error_count);
        end
        total++;
        if (e_err != 12) begin
            bad++; $display("FAIL sa1_model_count: model %0d want 12", e_err);
        end
    endtask

    task automatic test_saturation();
        int e_err, e_fm, e_fa, cyc;
        bit to;
        clear_faults();
        for (int m = 0; m < NM; m++)
            for (int a = 0; a < NW; a++) begin
                sa0[m][a] = 64'h1;
                sa1[m][a] = 64'h2;
            end
        model_run(e_err, e_fm, e_fa);
        run_dut(-1, cyc, to);
        $display("saturation: err=%0d fail_mem=%0d fail_addr=%0d", error_count, fail_mem, fail_addr);
        total++;
        if (to || {pass, error_count, fail_mem, fail_addr} !== {1'b0, 8'd255, 3'd0, 4'd0}) begin
            bad++; $display("FAIL saturation: got pass=%0d err=%0d mem=%0d addr=%0d want 0 255 0 0",
                            pass, error_count, fail_mem, fail_addr);
        end
        total++;
        if (error_count !== 8'(e_err)) begin
            bad++; $display("FAIL saturation_model: err got %0d want %0d", error_count, e_err);
        end
    endtask

    initial begin
        clear_faults();
        for (int m = 0; m < NM; m++)
            for (int a = 0; a < NW; a++) mem_arr[m][a] = {$urandom, $urandom};
        test_reset();
        test_clean();
        test_single_sa0();
        test_random_faults();
        test_restart_ignored();
        test_reset_midrun();
        test_sa1_addr0();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
